// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: round-robin common-bus arbiter, one processor owner with one nested snoop/memory grant.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module com_bus_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] Com_Bus_Req_proc,
  input  logic [NUM_REQ-1:0] Com_Bus_Req_snoop,
  input  logic               Mem_snoop_req,
  output logic [NUM_REQ-1:0] Com_Bus_Gnt_proc,
  output logic [NUM_REQ-1:0] Com_Bus_Gnt_snoop,
  output logic               Mem_snoop_gnt,
  output logic [3:0]         Bus_owner,
  output logic               Arb_timeout_err
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, PROC, NEST, SOLO} state_t;
  state_t state, state_r, state_n;
  logic [IW-1:0] owner, owner_n, nidx, nidx_n, last, last_n, rr_idx;
  logic nmem, nmem_n, nreq, oreq, rm, gm_n, to_hit;
  logic [NUM_REQ-1:0] rp, rs, elig, gp_n, gs_n;
  logic [3:0] bo_n;

  function automatic logic [IW-1:0] lowest(input logic [NUM_REQ-1:0] v);
    lowest = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (v[i]) lowest = IW'(i);
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] blk_p, blk_s;
  logic blk_m;
  assign rp = Com_Bus_Req_proc & ~blk_p;
  assign rs = Com_Bus_Req_snoop & ~blk_s;
  assign rm = Mem_snoop_req & ~blk_m;
  assign to_hit = state != IDLE && state_r == state && cnt == CW'(TIMEOUT - 1);
  // A timed-out requester stays masked until it lowers its request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      blk_p <= '0;
      blk_s <= '0;
      blk_m <= 1'b0;
      Arb_timeout_err <= 1'b0;
    end else begin
      cnt <= state_n != state ? '0 : state != IDLE ? cnt + CW'(1) : cnt;
      blk_p <= (blk_p & Com_Bus_Req_proc) | (to_hit ? Com_Bus_Gnt_proc : '0);
      blk_s <= (blk_s & Com_Bus_Req_snoop) | (to_hit ? Com_Bus_Gnt_snoop : '0);
      blk_m <= (blk_m & Mem_snoop_req) | (to_hit & Mem_snoop_gnt);
      Arb_timeout_err <= to_hit;
    end
  end
`else
  assign rp = Com_Bus_Req_proc;
  assign rs = Com_Bus_Req_snoop;
  assign rm = Mem_snoop_req;
  assign to_hit = 1'b0;
  // TIMEOUT only matters with the watchdog built in; this is constant 0.
  assign Arb_timeout_err = TIMEOUT < 0;
`endif

  always_comb begin
    rr_idx = last;
    for (int k = NUM_REQ; k >= 1; k--)
      if (rp[(int'(last) + k) % NUM_REQ]) rr_idx = IW'((int'(last) + k) % NUM_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      nidx <= '0;
      nmem <= 1'b0;
      last <= IW'(NUM_REQ - 1);
      Com_Bus_Gnt_proc <= '0;
      Com_Bus_Gnt_snoop <= '0;
      Mem_snoop_gnt <= 1'b0;
      Bus_owner <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      nidx <= nidx_n;
      nmem <= nmem_n;
      last <= last_n;
      Com_Bus_Gnt_proc <= gp_n;
      Com_Bus_Gnt_snoop <= gs_n;
      Mem_snoop_gnt <= gm_n;
      Bus_owner <= bo_n;
    end
  end

  always_comb begin
    elig = rs & ~(NUM_REQ'(1) << owner);
    nreq = nmem ? rm : rs[nidx];
    oreq = rp[owner];
    state_r = state;
    owner_n = owner;
    nidx_n = nidx;
    nmem_n = nmem;
    last_n = last;
    case (state)
      IDLE:
        if (|rs) begin
          state_r = SOLO;
          nidx_n = lowest(rs);
          nmem_n = 1'b0;
        end else if (rm) begin
          state_r = SOLO;
          nmem_n = 1'b1;
        end else if (|rp) begin
          state_r = PROC;
          owner_n = rr_idx;
          last_n = rr_idx;
        end
      PROC:
        if (!oreq) state_r = IDLE;
        else if (|elig) begin
          state_r = NEST;
          nidx_n = lowest(elig);
          nmem_n = 1'b0;
        end else if (rm) begin
          state_r = NEST;
          nmem_n = 1'b1;
        end
      NEST: state_r = nreq ? (oreq ? NEST : SOLO) : (oreq ? PROC : IDLE);
      default: state_r = nreq ? SOLO : IDLE;
    endcase
    state_n = to_hit ? IDLE : state_r;
  end

  always_comb begin
    gp_n = (state_n == PROC || state_n == NEST) ? NUM_REQ'(1) << owner_n : '0;
    gs_n = (state_n == NEST || state_n == SOLO) && !nmem_n ? NUM_REQ'(1) << nidx_n : '0;
    gm_n = (state_n == NEST || state_n == SOLO) && nmem_n;
    bo_n = (state_n == PROC || state_n == NEST) ? {1'b1, 3'(owner_n)} : 4'd0;
  end
endmodule

// File: tb/tb_com_bus_arbiter.sv
// tb_com_bus_arbiter: directed scenarios plus randomized traffic against a holder-based reference model.
module tb_com_bus_arbiter;
  localparam int N = 8;
  localparam int TO = 8;
  localparam int AW = 2 * N + 6;
  logic clk = 1'b0, rst = 1'b1, req_m = 1'b0;
  logic [N-1:0] req_p = '0, req_s = '0;
  logic [N-1:0] gnt_p, gnt_s;
  logic gnt_m, err;
  logic [3:0] owner;
  logic [AW-1:0] act;
  int vecs = 0, errs = 0;
  int m_own, m_side, m_last, m_held;
  logic [N-1:0] m_bp, m_bs;
  logic m_bm, m_err;

  com_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .Com_Bus_Req_proc(req_p), .Com_Bus_Req_snoop(req_s), .Mem_snoop_req(req_m),
    .Com_Bus_Gnt_proc(gnt_p), .Com_Bus_Gnt_snoop(gnt_s), .Mem_snoop_gnt(gnt_m),
    .Bus_owner(owner), .Arb_timeout_err(err)
  );

  always #5 clk = ~clk;
  assign act = {gnt_p, gnt_s, gnt_m, owner, err};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Model: m_own is the processor owner (-1 none); m_side is the snoop index, N for memory, -1 none.
  function automatic int lowest_bit(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_side = -1; m_last = N - 1; m_held = 0;
    m_bp = '0; m_bs = '0; m_bm = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] s, input logic m);
    logic [N-1:0] ep, es;
    logic em, oh, nh;
    int po, ps;
    ep = p & ~m_bp; es = s & ~m_bs; em = m & ~m_bm;
    m_bp &= p; m_bs &= s; m_bm &= m;
    po = m_own; ps = m_side; m_err = 1'b0;
    oh = po >= 0 ? ep[po] : 1'b0;
    nh = ps == N ? em : (ps >= 0 ? es[ps] : 1'b0);
    if (po < 0 && ps < 0) begin
      if (es != 0) m_side = lowest_bit(es);
      else if (em) m_side = N;
      else if (ep != 0)
        for (int k = 1; k <= N; k++)
          if (ep[(m_last + k) % N]) begin m_own = (m_last + k) % N; m_last = m_own; break; end
    end else if (ps < 0) begin
      if (!oh) m_own = -1;
      else begin
        es[po] = 1'b0;
        if (es != 0) m_side = lowest_bit(es);
        else if (em) m_side = N;
      end
    end else begin
      if (!nh) m_side = -1;
      if (!oh) m_own = -1;
    end
`ifdef ARB_TIMEOUT_EN
    if (m_own == po && m_side == ps && (po >= 0 || ps >= 0)) begin
      if (m_held == TO) begin
        if (po >= 0) m_bp[po] = 1'b1;
        if (ps == N) m_bm = 1'b1; else if (ps >= 0) m_bs[ps] = 1'b1;
        m_own = -1; m_side = -1; m_err = 1'b1; m_held = 0;
      end else m_held++;
    end else m_held = 1;
`endif
  endtask

  function automatic logic [AW-1:0] model_out();
    logic [N-1:0] gp, gs;
    logic gm;
    logic [3:0] bo;
    gp = '0; gs = '0; gm = 1'b0; bo = '0;
    if (m_own >= 0) begin gp[m_own] = 1'b1; bo = {1'b1, 3'(m_own)}; end
    if (m_side == N) gm = 1'b1; else if (m_side >= 0) gs[m_side] = 1'b1;
    return {gp, gs, gm, bo, m_err};
  endfunction

  task automatic tick(input logic r, input logic [N-1:0] p, input logic [N-1:0] s, input logic m);
    @(negedge clk);
    rst = r; req_p = p; req_s = s; req_m = m;
    if (r) model_reset(); else model_step(p, s, m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1, '1, '1, 1'b1);
    tick(1, '0, '0, 1'b0);
    vecs++;
    if (act !== '0) begin errs++; $display("FAIL reset_outputs: got %h want 0", act); end
    tick(0, '0, '0, 1'b0);
    vecs++;
    if (act !== model_out()) begin errs++; $display("FAIL reset_idle: got %h want %h", act, model_out()); end
  endtask

  task automatic test_single();
    tick(1, '0, '0, 1'b0);
    tick(0, 8'h04, '0, 1'b0);
    vecs++;
    if (gnt_p !== 8'h04 || owner !== 4'b1010) begin
      errs++; $display("FAIL single_grant: gnt %h owner %h want 04 a", gnt_p, owner);
    end
    for (int c = 0; c < 3; c++) begin
      tick(0, 8'h04, '0, 1'b0);
      vecs++;
      if (act !== model_out()) begin errs++; $display("FAIL single_hold: got %h want %h", act, model_out()); end
    end
    tick(0, '0, '0, 1'b0);
    vecs++;
    if (gnt_p !== '0 || owner !== 4'd0) begin
      errs++; $display("FAIL single_release: gnt %h owner %h want 00 0", gnt_p, owner);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rps [7] = '{8'h49, 8'h48, 8'h49, 8'h41, 8'h49, 8'h09, 8'h49};
    logic [N-1:0] exp [7] = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h40, 8'h00, 8'h01};
    logic [N-1:0] rps2 [3] = '{8'h04, 8'h00, 8'h22};
    logic [N-1:0] exp2 [3] = '{8'h04, 8'h00, 8'h20};
    tick(1, '0, '0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(0, rps[i], '0, 1'b0);
      vecs++;
      if (gnt_p !== exp[i] || act !== model_out()) begin
        errs++; $display("FAIL rr_order[%0d]: gnt %h want %h (all %h want %h)", i, gnt_p, exp[i], act, model_out());
      end
    end
    tick(1, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(0, rps2[i], '0, 1'b0);
      vecs++;
      if (gnt_p !== exp2[i]) begin errs++; $display("FAIL rr_last2[%0d]: gnt %h want %h", i, gnt_p, exp2[i]); end
    end
  endtask

  task automatic test_nesting();
    logic [N-1:0] rps [9] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00};
    logic [N-1:0] rss [9] = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h06, 8'h06, 8'h00};
    logic rms [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2*N:0] exp [9] = '{{8'h02, 8'h00, 1'b0}, {8'h02, 8'h10, 1'b0}, {8'h02, 8'h00, 1'b0},
                             {8'h02, 8'h00, 1'b1}, {8'h02, 8'h00, 1'b0}, {8'h02, 8'h00, 1'b0},
                             {8'h02, 8'h04, 1'b0}, {8'h00, 8'h04, 1'b0}, {8'h00, 8'h00, 1'b0}};
    tick(1, '0, '0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick(0, rps[i], rss[i], rms[i]);
      vecs++;
      if ({gnt_p, gnt_s, gnt_m} !== exp[i] || act !== model_out()) begin
        errs++; $display("FAIL nest[%0d]: got %h want %h (all %h want %h)", i, {gnt_p, gnt_s, gnt_m}, exp[i], act, model_out());
      end
    end
  endtask

  task automatic test_owner_drop();
    tick(1, '0, '0, 1'b0);
    tick(0, 8'h01, '0, 1'b0);
    tick(0, 8'h01, 8'h04, 1'b0);
    vecs++;
    if (gnt_p !== 8'h01 || gnt_s !== 8'h04) begin errs++; $display("FAIL drop_nested: p %h s %h want 01 04", gnt_p, gnt_s); end
    tick(0, 8'h00, 8'h04, 1'b0);
    vecs++;
    if (gnt_p !== 8'h00 || gnt_s !== 8'h04 || owner !== 4'd0) begin
      errs++; $display("FAIL drop_solo: p %h s %h owner %h want 00 04 0", gnt_p, gnt_s, owner);
    end
  endtask

  task automatic test_reset_mid();
    tick(1, '0, '0, 1'b0);
    tick(0, 8'h01, '0, 1'b0);
    tick(0, 8'h01, 8'h02, 1'b0);
    vecs++;
    if (gnt_s !== 8'h02) begin errs++; $display("FAIL mid_nest: s %h want 02", gnt_s); end
    tick(1, 8'h01, 8'h02, 1'b0);
    vecs++;
    if (act !== '0) begin errs++; $display("FAIL mid_reset: got %h want 0", act); end
    tick(0, 8'h21, '0, 1'b0);
    vecs++;
    if (gnt_p !== 8'h01) begin errs++; $display("FAIL mid_after: p %h want 01", gnt_p); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int high = 0, pulses = 0;
    tick(1, '0, '0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick(0, 8'h08, '0, 1'b0);
      high += gnt_p[3];
      pulses += err;
      vecs++;
      if (act !== model_out()) begin errs++; $display("FAIL timeout_cycle[%0d]: got %h want %h", c, act, model_out()); end
    end
    vecs++;
    if (high != TO || pulses != 1) begin
      errs++; $display("FAIL timeout_counts: high %0d pulses %0d want %0d 1", high, pulses, TO);
    end
    tick(0, '0, '0, 1'b0);
    tick(0, 8'h08, '0, 1'b0);
    vecs++;
    if (gnt_p !== 8'h08) begin errs++; $display("FAIL timeout_regrant: p %h want 08", gnt_p); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] p, s;
    logic m;
    p = '0; s = '0; m = 1'b0;
    tick(1, '0, '0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5) == 0) p[b] = ~p[b];
        if ($urandom_range(9) == 0) s[b] = ~s[b];
      end
      if ($urandom_range(9) == 0) m = ~m;
      tick($urandom_range(499) == 0, p, s, m);
      vecs++;
      if (act !== model_out()) begin
        errs++; $display("FAIL random[%0d]: got %h want %h", c, act, model_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_nesting();
    test_owner_drop();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
